fp_mul_seq: RTL

FP_MUL_SEQ -- requirements
Module: fp_mul_seq

---
 rtl/fp_mul_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier: 24-cycle shift-add significand multiply, then round and pack.
// Define FP_MUL_SPECIAL_EN to decode exponent-255 operands (NaN / infinity); otherwise they are ordinary exponents.
module fp_mul_seq (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_overflow,
  output logic        o_underflow,
  output logic        o_busy
);

  typedef enum logic [2:0] {IDLE, MUL, ROUND, PACK, DONE} state_t;

  state_t             state, state_nxt;
  logic [4:0]         cnt;
  logic [47:0]        acc;
  logic [23:0]        mcand, mplier;
  logic [7:0]         a_exp, b_exp;
  logic               sign;
  logic               zero_op;
  logic signed [9:0]  exp_r;
  logic [22:0]        mant_r;

`ifdef FP_MUL_SPECIAL_EN
  logic a_max, b_max, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic nan_op, inf_op;

  assign a_max  = &i_a[30:23];
  assign b_max  = &i_b[30:23];
  assign a_nan  = a_max & (|i_a[22:0]);
  assign b_nan  = b_max & (|i_b[22:0]);
  assign a_inf  = a_max & ~(|i_a[22:0]);
  assign b_inf  = b_max & ~(|i_b[22:0]);
  assign a_zero = ~(|i_a[30:23]);
  assign b_zero = ~(|i_b[30:23]);
`endif

  // p carries product bits [47:22]; returns {exp[9:0], frac[22:0]} rounded half-up without sticky.
  function automatic logic [32:0] round_product(input logic [25:0] p,
                                                input logic [7:0] x_exp,
                                                input logic [7:0] y_exp);
    logic signed [9:0] e;
    logic [22:0]       f;
    logic              c;
    if (p[25]) begin
      f = p[24:2] + {22'b0, p[1]};
      c = (&p[24:2]) & p[1];
      e = $signed({2'b00, x_exp}) + $signed({2'b00, y_exp}) - 10'sd126;
    end else begin
      f = p[23:1] + {22'b0, p[0]};
      c = (&p[24:1]) & p[0];
      e = $signed({2'b00, x_exp}) + $signed({2'b00, y_exp}) - 10'sd127;
    end
    // A carry out of the significand wraps the fraction to zero; only the exponent moves.
    if (c)
      e = e + 10'sd1;
    return {e, f};
  endfunction

  // Returns {result[31:0], overflow, underflow}.
  function automatic logic [33:0] saturate(input logic s,
                                           input logic signed [9:0] e,
                                           input logic [22:0] f);
    if (e >= 10'sd255)
      return {s, 8'hFF, 23'b0, 2'b10};
    else if (e <= 10'sd0)
      return {s, 31'b0, 2'b01};
    else
      return {s, e[7:0], f, 2'b00};
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid) state_nxt = MUL;
      MUL:     if (cnt == 5'd23) state_nxt = ROUND;
      ROUND:   state_nxt = PACK;
      PACK:    state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE);
    o_busy  = (state != IDLE);
    o_valid = (state == DONE);
  end

  // Operand capture: only an accepted handshake in IDLE loads these.
  always_ff @(posedge i_clk) begin
    if (state == IDLE && i_valid) begin
      sign    <= i_a[31] ^ i_b[31];
      a_exp   <= i_a[30:23];
      b_exp   <= i_b[30:23];
      mcand   <= {|i_a[30:23], i_a[22:0]};
      mplier  <= {|i_b[30:23], i_b[22:0]};
      zero_op <= ~(|i_a[30:23]) | ~(|i_b[30:23]);
`ifdef FP_MUL_SPECIAL_EN
      nan_op  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
      inf_op  <= a_inf | b_inf;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (state == ROUND)
      {exp_r, mant_r} <= round_product(acc[47:22], a_exp, b_exp);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt         <= 5'd0;
      acc         <= 48'd0;
      o_result    <= 32'd0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          cnt <= 5'd0;
          acc <= 48'd0;
        end
        MUL: begin
          if (mplier[cnt])
            acc <= acc + ({24'b0, mcand} << cnt);
          cnt <= cnt + 5'd1;
        end
        PACK: begin
`ifdef FP_MUL_SPECIAL_EN
          if (nan_op)
            {o_result, o_overflow, o_underflow} <= {32'h7FC00000, 2'b00};
          else if (inf_op)
            {o_result, o_overflow, o_underflow} <= {sign, 8'hFF, 23'b0, 2'b00};
          else
`endif
          if (zero_op)
            {o_result, o_overflow, o_underflow} <= {sign, 31'b0, 2'b00};
          else
            {o_result, o_overflow, o_underflow} <= saturate(sign, exp_r, mant_r);
        end
        default: ;
      endcase
    end
  end

endmodule
